excess3_to_bcd_serial: RTL
==========================

Name: excess3_to_bcd_serial

Overview:
- Multi-digit excess-3 to packed-BCD decoder; the receive-side counterpart of the team's BCD-to-excess-3 encoder.
- Accepts one packed excess-3 word per valid/ready transaction and decodes one digit per clock, least-significant digit first.
- Returns packed BCD plus per-digit invalid-code flags over a valid/ready output.
- Sits between serial/display datapaths that carry excess-3 and downstream BCD arithmetic.

Parameters:
- DIGITS, 4, number of 4-bit digits per word (1..16).
- CNT_W, 4, width of the digit index counter; must satisfy 2^CNT_W >= DIGITS.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word.
- in_data  input  4*DIGITS  packed excess-3 word; digit i = in_data[4i+3:4i].
- out_valid  output  1  decoded result available.
- out_ready  input  1  downstream accepts result.
- out_bcd  output  4*DIGITS  packed BCD result; digit i = out_bcd[4i+3:4i].
- out_err  output  1  OR of out_err_mask.
- out_err_mask  output  DIGITS  bit i set = input digit i was an invalid excess-3 code.

Behaviour:
- Reset (rst=1 at edge): state IDLE, in_ready=1, out_valid=0, out_bcd=0, out_err_mask=0, out_err=0, digit index=0. Reset wins over every other event; a partial conversion is discarded with no output.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On in_valid&in_ready at an edge: capture in_data, clear the working result and mask, set index=0, go to CONV.
  - CONV: in_ready=0, out_valid=0. Each edge decodes digit[index] into working result digit[index] and increments index. The edge that decodes digit DIGITS-1 goes to DONE.
  - DONE: out_valid=1, in_ready=0. out_bcd, out_err_mask and out_err are held stable until out_valid&out_ready at an edge, then go to IDLE.
- Digit decode:
  - Code 0011..1100 -> code minus 3 (4-bit subtract, no borrow possible); mask bit 0.
  - Codes 0000, 0001, 0010, 1101, 1110, 1111 -> digit 0000; mask bit i set.
- Latency: accept edge E -> out_valid high in the cycle after edge E+DIGITS.
- Throughput: one word per DIGITS+2 cycles minimum with out_ready held high. No overlap; in_ready is high only in IDLE.
- Output registers keep their last values after the output handshake, until the next DONE overwrites them. They are not cleared on IDLE entry.
- in_data is sampled only at the accept edge; later changes are ignored.
- in_valid asserted outside IDLE has no effect.
- out_ready while not in DONE is ignored.
- out_err is combinational from the registered mask.
- DIGITS=1 is legal: one CONV cycle.

Test Plan:
- Reset then idle: rst high 2 cycles -> in_ready=1, out_valid=0, out_bcd=0x0000, out_err_mask=4'b0000.
- Basic decode, DIGITS=4, out_ready=1: in_data=0x3456 accepted at edge E -> out_valid rises after edge E+4, out_bcd=0x0123, out_err=0. The next cycle returns to IDLE with in_ready=1.
- Full-range digits: 0xCCCC -> 0x9999; 0x3333 -> 0x0000; 0x789A -> 0x4567. All with mask 0.
- Invalid codes: 0x3F43 -> out_bcd=0x0010, out_err_mask=4'b0100, out_err=1. 0x0D21 -> out_bcd=0x0000, mask=4'b1111.
- Backpressure: 0x5A7C decoded, out_ready low for 5 cycles -> out_valid held 1, out_bcd=0x2749 stable, in_ready=0 with in_valid=1 and a new word ignored. out_ready high -> single handshake, IDLE next cycle.
- Reset mid-operation: accept 0x4444, assert rst at the second CONV edge -> IDLE, out_valid never asserted, outputs 0. A following word 0x3456 decodes normally to 0x0123.

Source files
------------

// File: rtl/excess3_to_bcd_serial_if.sv
// Purpose: valid/ready bundle carrying excess-3 words in and packed BCD results out.
// Latency: none, wires only.
// Backpressure: in_ready/out_ready carry the flow control; the bundle itself holds no state.
interface excess3_to_bcd_serial_if #(
  parameter int DIGITS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_bcd;
  logic                  out_err;
  logic [DIGITS-1:0]     out_err_mask;

  // Environment side: supplies words, consumes results.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_bcd, out_err, out_err_mask
  );

  // Decoder side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_bcd, out_err, out_err_mask
  );
endinterface

// File: rtl/excess3_to_bcd_serial.sv
// Purpose: decode a packed excess-3 word to packed BCD, one digit per clock, LSD first, flagging bad codes.
// Latency: out_valid rises in the cycle after accept edge + DIGITS; at best one word per DIGITS+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, so words never overlap.
module excess3_to_bcd_serial #(
  parameter int DIGITS = 4,
  parameter int CNT_W  = 4
) (
  input logic                    clk,
  input logic                    rst,
  excess3_to_bcd_serial_if.slave bus
);
  localparam int              W        = 4 * DIGITS;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [W-1:0]      cap_word;
  logic [W-1:0]      work_bcd;
  logic [W-1:0]      work_bcd_next;
  logic [DIGITS-1:0] work_mask;
  logic [DIGITS-1:0] work_mask_next;
  logic [W-1:0]      res_bcd;
  logic [DIGITS-1:0] res_mask;
  logic [CNT_W-1:0]  idx;
  logic [3:0]        cur_code;
  logic [3:0]        cur_digit;
  logic              cur_bad;
  logic              accept;
  logic              last_digit;
  logic              release_out;

  assign accept      = (state == IDLE) && bus.in_valid;
  assign last_digit  = (idx == LAST_IDX);
  assign release_out = (state == DONE) && bus.out_ready;

  // State register; reset abandons any conversion in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: one CONV cycle per digit, DONE waits for the downstream handshake.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)      state_next = CONV;
      CONV:    if (last_digit)  state_next = DONE;
      DONE:    if (release_out) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs depend only on the state, so neither side sees a combinational path.
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
  end

  // Decode the digit under the index; out-of-range codes become 0 and raise their mask bit.
  always_comb begin
    cur_code       = cap_word[4*int'(idx) +: 4];
    cur_bad        = (cur_code < 4'd3) || (cur_code > 4'd12);
    cur_digit      = cur_bad ? 4'd0 : (cur_code - 4'd3);
    work_bcd_next  = work_bcd;
    work_mask_next = work_mask;
    work_bcd_next[4*int'(idx) +: 4] = cur_digit;
    work_mask_next[int'(idx)]       = cur_bad;
  end

  // Datapath: capture on accept, accumulate while converting, publish on the last digit.
  // The published result survives IDLE and is only replaced by the next completed word.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_word  <= '0;
      work_bcd  <= '0;
      work_mask <= '0;
      idx       <= '0;
      res_bcd   <= '0;
      res_mask  <= '0;
    end else if (accept) begin
      cap_word  <= bus.in_data;
      work_bcd  <= '0;
      work_mask <= '0;
      idx       <= '0;
    end else if (state == CONV) begin
      work_bcd  <= work_bcd_next;
      work_mask <= work_mask_next;
      if (last_digit) begin
        res_bcd  <= work_bcd_next;
        res_mask <= work_mask_next;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign bus.out_bcd      = res_bcd;
  assign bus.out_err_mask = res_mask;
  assign bus.out_err      = |res_mask;

endmodule
